// File: rtl/clock_time_ctrl_if.sv
// Bundle of the clock sequencer signals between the tick divider,
// button synchronisers, the three counters and the sequencer itself.
interface clock_time_ctrl_if #(
    parameter int DW = 6
);
    logic          i_tick;
    logic          i_btn_mode;
    logic          i_btn_inc;
    logic [DW-1:0] i_sec_count;
    logic [DW-1:0] i_min_count;
    logic          o_sec_ena;
    logic          o_sec_clr;
    logic          o_min_ena;
    logic          o_min_add;
    logic          o_hr_ena;
    logic          o_hr_add;
    logic [1:0]    o_state;
    logic          o_blink;

    // Surrounding logic: supplies tick, buttons and count feedback.
    modport master (
        output i_tick, i_btn_mode, i_btn_inc, i_sec_count, i_min_count,
        input  o_sec_ena, o_sec_clr, o_min_ena, o_min_add,
               o_hr_ena, o_hr_add, o_state, o_blink
    );

    // The sequencer.
    modport slave (
        input  i_tick, i_btn_mode, i_btn_inc, i_sec_count, i_min_count,
        output o_sec_ena, o_sec_clr, o_min_ena, o_min_add,
               o_hr_ena, o_hr_add, o_state, o_blink
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// Sequencer for the sec/min/hr counter chain of the digital clock.
// RUN: converts the 1 Hz tick into count enables and carries.
// SET_HR / SET_MIN: user adjusts the time with mode/inc buttons.
// Optional macro AUTO_REPEAT_EN: holding inc in a SET state auto-repeats
// one add pulse per tick after REPEAT_DLY ticks.
module clock_time_ctrl #(
    parameter int SEC_LIMIT  = 60,
    parameter int MIN_LIMIT  = 60,
    parameter int DW         = 6,
    parameter int REPEAT_DLY = 2
) (
    input  logic              clk,
    input  logic              rst,
    clock_time_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    state_t state_reg;
    logic   mode_q_reg;
    logic   inc_q_reg;
    logic   sec_ena_reg, sec_clr_reg, min_ena_reg, min_add_reg;
    logic   hr_ena_reg, hr_add_reg, blink_reg;

    logic mode_press;
    logic inc_press;
    logic sec_wrap;
    logic min_wrap;
    logic in_set;
    logic rpt_fire;
    logic add_req;

    assign mode_press = bus.i_btn_mode & ~mode_q_reg;
    assign inc_press  = bus.i_btn_inc & ~inc_q_reg;
    assign sec_wrap   = (bus.i_sec_count == DW'(SEC_LIMIT - 1));
    assign min_wrap   = (bus.i_min_count == DW'(MIN_LIMIT - 1));
    assign in_set     = (state_reg == ST_SET_HR) || (state_reg == ST_SET_MIN);
    assign add_req    = inc_press | rpt_fire;

`ifdef AUTO_REPEAT_EN
    localparam int RW = (REPEAT_DLY < 1) ? 1 : $clog2(REPEAT_DLY + 1);
    logic [RW-1:0] rpt_cnt_reg;

    // A tick while inc is still held (not the press cycle itself) repeats once saturated.
    assign rpt_fire = in_set & bus.i_btn_inc & ~inc_press & ~mode_press &
                      bus.i_tick & (rpt_cnt_reg == RW'(REPEAT_DLY));

    // Count ticks while inc is held in a SET state; saturates at REPEAT_DLY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt_reg <= '0;
        end else if (!in_set || !bus.i_btn_inc || inc_press || mode_press) begin
            rpt_cnt_reg <= '0;
        end else if (bus.i_tick && (rpt_cnt_reg != RW'(REPEAT_DLY))) begin
            rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^REPEAT_DLY;
    assign rpt_fire   = 1'b0;
`endif

    // Mode FSM with registered single-cycle pulse outputs and blink gate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_RUN;
            mode_q_reg  <= 1'b0;
            inc_q_reg   <= 1'b0;
            sec_ena_reg <= 1'b0;
            sec_clr_reg <= 1'b0;
            min_ena_reg <= 1'b0;
            min_add_reg <= 1'b0;
            hr_ena_reg  <= 1'b0;
            hr_add_reg  <= 1'b0;
            blink_reg   <= 1'b1;
        end else begin
            mode_q_reg  <= bus.i_btn_mode;
            inc_q_reg   <= bus.i_btn_inc;
            sec_ena_reg <= 1'b0;
            sec_clr_reg <= 1'b0;
            min_ena_reg <= 1'b0;
            min_add_reg <= 1'b0;
            hr_ena_reg  <= 1'b0;
            hr_add_reg  <= 1'b0;
            case (state_reg)
                ST_RUN: begin
                    blink_reg <= 1'b1;
                    if (mode_press) begin
                        // A coincident tick is deliberately lost.
                        state_reg <= ST_SET_HR;
                        blink_reg <= 1'b0;
                    end else if (bus.i_tick) begin
                        sec_ena_reg <= 1'b1;
                        min_ena_reg <= sec_wrap;
                        hr_ena_reg  <= sec_wrap & min_wrap;
                    end
                end
                ST_SET_HR: begin
                    if (mode_press) begin
                        state_reg <= ST_SET_MIN;
                        blink_reg <= 1'b0;
                    end else begin
                        hr_add_reg <= add_req;
                        if (bus.i_tick) blink_reg <= ~blink_reg;
                    end
                end
                ST_SET_MIN: begin
                    if (mode_press) begin
                        // Back to RUN: seconds restart from zero.
                        state_reg   <= ST_RUN;
                        sec_clr_reg <= 1'b1;
                        blink_reg   <= 1'b1;
                    end else begin
                        min_add_reg <= add_req;
                        if (bus.i_tick) blink_reg <= ~blink_reg;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                    blink_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_sec_ena = sec_ena_reg;
    assign bus.o_sec_clr = sec_clr_reg;
    assign bus.o_min_ena = min_ena_reg;
    assign bus.o_min_add = min_add_reg;
    assign bus.o_hr_ena  = hr_ena_reg;
    assign bus.o_hr_add  = hr_add_reg;
    assign bus.o_state   = state_reg;
    assign bus.o_blink   = blink_reg;
endmodule

// File: tb/tb_clock_time_ctrl.sv
// Testbench for clock_time_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model of the clock
// sequencer (mode index, blink flag, button history, repeat tick count).
module tb_clock_time_ctrl;
    localparam int DLY = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    clock_time_ctrl_if #(.DW(6)) bus ();

    clock_time_ctrl #(
        .SEC_LIMIT(60), .MIN_LIMIT(60), .DW(6), .REPEAT_DLY(DLY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int   m_mode;          // 0 RUN, 1 SET_HR, 2 SET_MIN
    logic m_blink;
    logic m_mode_q, m_inc_q;
    int   m_rpt;
    logic [5:0] m_pulses;  // {sec_ena, sec_clr, min_ena, min_add, hr_ena, hr_add}

    logic [5:0] pulses;
    assign pulses = {bus.o_sec_ena, bus.o_sec_clr, bus.o_min_ena,
                     bus.o_min_add, bus.o_hr_ena, bus.o_hr_add};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_blink = 1'b1; m_mode_q = 1'b0; m_inc_q = 1'b0;
        m_rpt = 0; m_pulses = '0;
    endtask

    // One clock of the clock-setting rules applied to the sampled inputs.
    task automatic model_step(input logic t, m, i, input logic [5:0] s, mn);
        logic mp, ip, rep;
        mp = m & ~m_mode_q;
        ip = i & ~m_inc_q;
        rep = 1'b0;
        m_pulses = '0;
        if (mp) begin
            if (m_mode == 2) m_pulses[4] = 1'b1;
            m_mode  = (m_mode + 1) % 3;
            m_blink = (m_mode == 0);
            m_rpt   = 0;
        end else if (m_mode == 0) begin
            m_blink = 1'b1;
            m_rpt   = 0;
            if (t) begin
                m_pulses[5] = 1'b1;
                m_pulses[3] = (s == 6'd59);
                m_pulses[1] = (s == 6'd59) && (mn == 6'd59);
            end
        end else begin
`ifdef AUTO_REPEAT_EN
            if (!i || ip) m_rpt = 0;
            else if (t) begin
                rep = (m_rpt >= DLY);
                if (m_rpt < DLY) m_rpt++;
            end
`endif
            if (ip || rep) begin
                if (m_mode == 1) m_pulses[0] = 1'b1;
                else             m_pulses[2] = 1'b1;
            end
            if (t) m_blink = ~m_blink;
        end
        m_mode_q = m;
        m_inc_q  = i;
    endtask

    // Apply one cycle of stimulus, advance the model, compare all outputs.
    task automatic step(input logic t, m, i, input logic [5:0] s = 6'd0, input logic [5:0] mn = 6'd0);
        @(negedge clk);
        bus.i_tick = t; bus.i_btn_mode = m; bus.i_btn_inc = i;
        bus.i_sec_count = s; bus.i_min_count = mn;
        @(posedge clk);
        model_step(t, m, i, s, mn);
        #1;
        check("state_blink", {29'd0, bus.o_state, bus.o_blink},
              {29'd0, 2'(m_mode), m_blink});
        check("pulses", {26'd0, pulses}, {26'd0, m_pulses});
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        check(tag, {23'd0, bus.o_state, bus.o_blink, pulses}, {23'd0, 2'b00, 1'b1, 6'd0});
        @(negedge clk);
        bus.i_tick = 1'b0; bus.i_btn_mode = 1'b0; bus.i_btn_inc = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    int   adds;
    logic rt, rm, ri;
    logic [5:0] rs, rmn;

    initial begin
        bus.i_tick = 1'b0; bus.i_btn_mode = 1'b0; bus.i_btn_inc = 1'b0;
        bus.i_sec_count = '0; bus.i_min_count = '0;
        #2;
        async_reset("reset_initial");

        // Full carry chain, then pulses drop after one cycle
        step(1'b1, 1'b0, 1'b0, 6'd59, 6'd59);
        check("carry_all", {26'd0, pulses}, 32'b101010);
        async_reset("reset_mid_pulse");
        step(1'b1, 1'b0, 1'b0, 6'd59, 6'd59);
        step(1'b0, 1'b0, 1'b0, 6'd59, 6'd59);
        check("carry_clear", {26'd0, pulses}, 32'd0);

        // Seconds only, then into SET_HR; tick toggles blink without ena
        step(1'b1, 1'b0, 1'b0, 6'd10, 6'd0);
        check("sec_only", {26'd0, pulses}, 32'b100000);
        step(1'b0, 1'b1, 1'b0);
        check("enter_hr", {29'd0, bus.o_state, bus.o_blink}, 32'b010);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("set_tick", {25'd0, bus.o_blink, pulses}, 32'b1000000);

        // Three hour increments, two minute increments, back to RUN
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1);
            check("hr_add", {26'd0, pulses}, 32'b000001);
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0);
        check("enter_min", {29'd0, bus.o_state, bus.o_blink}, 32'b100);
        step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 1'b1);
            check("min_add", {26'd0, pulses}, 32'b000100);
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, 6'd59, 6'd59);
        check("exit_clr", {24'd0, bus.o_state, pulses}, {24'd0, 2'b00, 6'b010000});
        step(1'b0, 1'b0, 1'b0);
        check("clr_one_cycle", {26'd0, pulses}, 32'd0);

        // Mode and inc together in SET_MIN: mode wins
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("mode_wins", {24'd0, bus.o_state, pulses}, {24'd0, 2'b00, 6'b010000});
        step(1'b0, 1'b0, 1'b0);

        // Inc held for five ticks in SET_MIN
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
        adds = 0;
        step(1'b0, 1'b0, 1'b1);
        adds += int'(bus.o_min_add);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b1); adds += int'(bus.o_min_add);
            step(1'b1, 1'b0, 1'b1); adds += int'(bus.o_min_add);
        end
        step(1'b0, 1'b0, 1'b0); adds += int'(bus.o_min_add);
`ifdef AUTO_REPEAT_EN
        check("held_adds", adds, 32'd4);
`else
        check("held_adds", adds, 32'd1);
`endif
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);

        // Random stimulus against the model, with one reset in the middle
        rm = 1'b0; ri = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                async_reset("reset_random");
                rm = 1'b0; ri = 1'b0;
            end
            rt = ($urandom_range(2, 0) == 0);
            if ($urandom_range(7, 0) == 0) rm = ~rm;
            if ($urandom_range(3, 0) == 0) ri = ~ri;
            rs  = ($urandom_range(1, 0) == 1) ? 6'd59 : 6'($urandom_range(58, 0));
            rmn = ($urandom_range(1, 0) == 1) ? 6'd59 : 6'($urandom_range(58, 0));
            step(rt, rm, ri, rs, rmn);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
